layer_mixer_nl: RTL



---
 rtl/layer_mixer_pkg.sv | 17 +
 rtl/mixer_delay_line.sv | 41 ++++
 rtl/layer_mixer_nl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/layer_mixer_pkg.sv
// Shared types for the layer mixer: FSM states, RGB pixel struct and
// raster-address helper.
package layer_mixer_pkg;

  typedef enum logic [1:0] {IDLE_ST, RUN_ST, DRAIN_ST} fsm_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  function automatic int addr_w(input int x, input int y, input int x_limit);
    return y * x_limit + x;
  endfunction

endpackage

// File: rtl/mixer_delay_line.sv
// Stallable shift register carrying a payload and a per-stage valid bit;
// keeps issued addresses aligned with the layer memory read latency.
module mixer_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] data_o,
  output logic             any_vld_o
);

  logic [DEPTH-1:0] vld_q;
  logic [WIDTH-1:0] data_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
    end else if (en_i) begin
      vld_q[0] <= vld_i;
      for (int i = 1; i < DEPTH; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  // Payload is only meaningful where the matching valid is set, so no reset.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      data_q[0] <= data_i;
      for (int i = 1; i < DEPTH; i++) data_q[i] <= data_q[i-1];
    end
  end

  assign vld_o     = vld_q[DEPTH-1];
  assign data_o    = data_q[DEPTH-1];
  assign any_vld_o = |vld_q;

endmodule

// File: rtl/layer_mixer_nl.sv
// Composes NUM_LAYERS 1-bit layers (layer 0 banked/animated) into RGB888
// pixels and streams them to the frame RAM writer with ready backpressure.
module layer_mixer_nl #(
  parameter int X_LIMIT     = 240,
  parameter int Y_LIMIT     = 240,
  parameter int NUM_LAYERS  = 4,
  parameter int BANK_LIMIT  = 9,
  parameter int MEM_LATENCY = 1,
  localparam int PIXEL_LIMIT = X_LIMIT * Y_LIMIT,
  localparam int ADDR_W      = $clog2(PIXEL_LIMIT),
  localparam int BANK_W      = $clog2(BANK_LIMIT)
) (
  input  logic                      CLK,
  input  logic                      RESETN,
  input  logic [31:0]               UPDATE_LIMIT,
  input  logic [7:0]                FRAME_DIVIDER,
  input  logic [NUM_LAYERS-1:0]     LAYER_ENABLE,
  input  logic [NUM_LAYERS*24-1:0]  LAYER_COLOR,
  input  logic [23:0]               BG_COLOR,
  output logic [ADDR_W-1:0]         LAYER_ADDRESS,
  output logic                      LAYER_READ_EN,
  output logic [BANK_W-1:0]         LAYER0_BANK,
  input  logic [BANK_LIMIT-1:0]     LAYER0_DATA,
  input  logic [NUM_LAYERS-2:0]     LAYER_DATA,
  output logic [ADDR_W-1:0]         WRITE_RAM_ADDRESS,
  output logic [7:0]                WRITE_RAM_COLOR_R,
  output logic [7:0]                WRITE_RAM_COLOR_G,
  output logic [7:0]                WRITE_RAM_COLOR_B,
  output logic                      WRITE_RAM,
  input  logic                      WRITE_RAM_READY,
  output logic                      FRAME_DONE,
  output logic                      BUSY
);
  import layer_mixer_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXEL_LIMIT - 1);
  localparam logic [BANK_W-1:0] BANK_MAX  = BANK_W'(BANK_LIMIT - 1);

  fsm_e                     st_q;
  logic [31:0]              idle_cnt_q;
  logic [31:0]              ulim_d;
  logic [ADDR_W-1:0]        addr_q;
  logic [7:0]               frame_cnt_q;
  logic [BANK_W-1:0]        bank_q;
  logic                     done_q;
  logic [NUM_LAYERS-1:0]    sh_en_q;
  logic [NUM_LAYERS*24-1:0] sh_col_q;
  rgb_t                     sh_bg_q;
  logic                     wr_q;
  logic [ADDR_W-1:0]        waddr_q;
  rgb_t                     pix_q;
  rgb_t                     mix_d;
  logic                     hit_d;
  logic [NUM_LAYERS-1:0]    opaque_d;
  logic                     advance, transfer, issuing, last_xfer;
  logic                     dl_vld, dl_any;
  logic [ADDR_W-1:0]        dl_addr;

  assign issuing   = (st_q == RUN_ST);
  assign transfer  = wr_q & WRITE_RAM_READY;
  assign advance   = ~wr_q | WRITE_RAM_READY;
  assign last_xfer = transfer & (st_q == DRAIN_ST) & (waddr_q == LAST_ADDR);
  assign ulim_d    = (UPDATE_LIMIT == 32'd0) ? 32'd1 : UPDATE_LIMIT;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      st_q        <= IDLE_ST;
      idle_cnt_q  <= '0;
      addr_q      <= '0;
      frame_cnt_q <= '0;
      bank_q      <= '0;
      done_q      <= 1'b0;
      sh_en_q     <= '0;
      sh_col_q    <= '0;
      sh_bg_q     <= '0;
    end else begin
      done_q <= last_xfer;
      case (st_q)
        IDLE_ST: begin
          if (idle_cnt_q >= ulim_d - 32'd1) begin
            st_q       <= RUN_ST;
            idle_cnt_q <= '0;
            addr_q     <= '0;
            sh_en_q    <= LAYER_ENABLE;
            sh_col_q   <= LAYER_COLOR;
            sh_bg_q    <= BG_COLOR;
          end else begin
            idle_cnt_q <= idle_cnt_q + 32'd1;
          end
        end
        RUN_ST: begin
          if (advance) begin
            if (addr_q == LAST_ADDR) st_q <= DRAIN_ST;
            else                     addr_q <= addr_q + 1'b1;
          end
        end
        DRAIN_ST: begin
          if (last_xfer) begin
            st_q <= IDLE_ST;
            // >= keeps the divider from running away if it is lowered mid-count
            if (frame_cnt_q >= FRAME_DIVIDER) begin
              frame_cnt_q <= '0;
              bank_q      <= (bank_q == BANK_MAX) ? '0 : bank_q + 1'b1;
            end else begin
              frame_cnt_q <= frame_cnt_q + 8'd1;
            end
          end
        end
        default: st_q <= IDLE_ST;
      endcase
    end
  end

  mixer_delay_line #(
    .DEPTH (MEM_LATENCY),
    .WIDTH (ADDR_W)
  ) u_align (
    .clk_i     (CLK),
    .rst_ni    (RESETN),
    .en_i      (advance),
    .vld_i     (issuing),
    .data_i    (addr_q),
    .vld_o     (dl_vld),
    .data_o    (dl_addr),
    .any_vld_o (dl_any)
  );

  // Highest-index enabled opaque layer wins; background when none is.
  always_comb begin
    opaque_d = {LAYER_DATA, LAYER0_DATA[bank_q]};
    mix_d    = sh_bg_q;
    hit_d    = 1'b0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (!hit_d && sh_en_q[i] && opaque_d[i]) begin
        hit_d = 1'b1;
        mix_d = sh_col_q[24*i +: 24];
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      wr_q    <= 1'b0;
      waddr_q <= '0;
      pix_q   <= '0;
    end else if (advance) begin
      wr_q <= dl_vld;
      if (dl_vld) begin
        waddr_q <= dl_addr;
        pix_q   <= mix_d;
      end
    end
  end

  assign LAYER_ADDRESS     = addr_q;
  assign LAYER_READ_EN     = advance & (issuing | dl_any);
  assign LAYER0_BANK       = bank_q;
  assign WRITE_RAM_ADDRESS = waddr_q;
  assign WRITE_RAM_COLOR_R = pix_q.r;
  assign WRITE_RAM_COLOR_G = pix_q.g;
  assign WRITE_RAM_COLOR_B = pix_q.b;
  assign WRITE_RAM         = wr_q;
  assign FRAME_DONE        = done_q;
  assign BUSY              = (st_q != IDLE_ST);

endmodule
